// File: rtl/nanov_reg_stream.sv
// Parallel/serial adapter for the nanoV bit-serial register file port.
// Write: word accepted at edge N, bits on data_rd in cycles N+1..N+32, ready again N+33.
// Capture: cap_start at edge N, samples edges N+1..N+32, result held until cap_ready.
module nanov_reg_stream #(
   parameter int WIDTH         = 32,
   parameter int CNT_BITS      = 5,
   parameter int REG_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [WIDTH-1:0]         load_data,
   input  logic [REG_ADDR_BITS-1:0] load_rd,
   output logic [REG_ADDR_BITS-1:0] rd,
   output logic                     wr_en,
   output logic                     wr_next_en,
   output logic                     data_rd,
   output logic                     data_rd_next,
   input  logic                     cap_start,
   input  logic [REG_ADDR_BITS-1:0] cap_rs,
   output logic [REG_ADDR_BITS-1:0] rs,
   input  logic                     data_rs,
   output logic                     cap_busy,
   output logic                     cap_valid,
   output logic [WIDTH-1:0]         cap_data,
   input  logic                     cap_ready
);

   localparam logic [0:0] W_IDLE  = 1'b0;
   localparam logic [0:0] W_SHIFT = 1'b1;

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_SHIFT = 2'd1;
   localparam logic [1:0] C_HOLD  = 2'd2;

   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH - 1);

   logic [0:0]          wstate;
   logic [WIDTH-1:0]    wsr;
   logic [CNT_BITS-1:0] wcnt;

   logic [1:0]          cstate;
   logic [WIDTH-1:0]    csr;
   logic [CNT_BITS-1:0] ccnt;

   logic                w_shifting;
   logic                w_last;

   // Write side: latch a word, then shift it out LSB first for WIDTH cycles.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wstate <= W_IDLE;
         wsr    <= '0;
         wcnt   <= '0;
         rd     <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (load_valid) begin
                  wsr    <= load_data;
                  rd     <= load_rd;
                  wcnt   <= '0;
                  wstate <= W_SHIFT;
               end
            end
            default: begin
               wsr  <= {1'b0, wsr[WIDTH-1:1]};
               wcnt <= wcnt + 1'b1;
               if (wcnt == LAST_BIT) begin
                  wstate <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Stream outputs decode from state and shift register only; the lookahead
   // bit is forced low on the final bit because there is no bit after it.
   always_comb begin
      w_shifting   = (wstate == W_SHIFT);
      w_last       = (wcnt == LAST_BIT);
      load_ready   = !w_shifting;
      wr_en        = w_shifting;
      wr_next_en   = w_shifting && !w_last;
      data_rd      = w_shifting && wsr[0];
      data_rd_next = w_shifting && !w_last && wsr[1];
   end

   // Capture side: shift data_rs in from the MSB end so bit 0 lands at csr[0],
   // then hold the word until the consumer takes it (optionally restarting at once).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cstate <= C_IDLE;
         csr    <= '0;
         ccnt   <= '0;
         rs     <= '0;
      end else begin
         case (cstate)
            C_IDLE: begin
               if (cap_start) begin
                  rs     <= cap_rs;
                  ccnt   <= '0;
                  cstate <= C_SHIFT;
               end
            end
            C_SHIFT: begin
               csr  <= {data_rs, csr[WIDTH-1:1]};
               ccnt <= ccnt + 1'b1;
               if (ccnt == LAST_BIT) begin
                  cstate <= C_HOLD;
               end
            end
            C_HOLD: begin
               if (cap_ready) begin
                  if (cap_start) begin
                     rs     <= cap_rs;
                     ccnt   <= '0;
                     cstate <= C_SHIFT;
                  end else begin
                     cstate <= C_IDLE;
                  end
               end
            end
            default: cstate <= C_IDLE;
         endcase
      end
   end

   // Capture status decodes from state; the word is visible straight from csr.
   always_comb begin
      cap_busy  = (cstate != C_IDLE);
      cap_valid = (cstate == C_HOLD);
      cap_data  = csr;
   end

endmodule

// File: tb/tb_nanov_reg_stream.sv
// Directed + randomized bench for nanov_reg_stream.
// Expected stream/capture values are derived from the word bits and cycle offsets.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_nanov_reg_stream;

   logic        clk = 1'b0;
   logic        rstn;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic [3:0]  load_rd;
   logic [3:0]  rd;
   logic        wr_en;
   logic        wr_next_en;
   logic        data_rd;
   logic        data_rd_next;
   logic        cap_start;
   logic [3:0]  cap_rs;
   logic [3:0]  rs;
   logic        data_rs;
   logic        cap_busy;
   logic        cap_valid;
   logic [31:0] cap_data;
   logic        cap_ready;

   int checks = 0;
   int errors = 0;

   nanov_reg_stream #(.WIDTH(32), .CNT_BITS(5), .REG_ADDR_BITS(4)) dut (
      .clk(clk), .rstn(rstn),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_rd(load_rd),
      .rd(rd), .wr_en(wr_en), .wr_next_en(wr_next_en), .data_rd(data_rd), .data_rd_next(data_rd_next),
      .cap_start(cap_start), .cap_rs(cap_rs), .rs(rs), .data_rs(data_rs),
      .cap_busy(cap_busy), .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic bit_of(input logic [31:0] w, input int i);
      logic [31:0] t;
      t = w >> i;
      return (i < 32) ? t[0] : 1'b0;
   endfunction

   // Runs an optional write (started at t=0) and an optional capture (started at t=cd).
   // hold = cycles cap_ready stays low once the word is ready; poke = stray cap_start mid-capture.
   task automatic run_ops(input bit do_w, input logic [31:0] ww, input logic [3:0] wr,
                          input bit do_c, input logic [31:0] cw, input logic [3:0] cr,
                          input int cd, input bit poke, input int hold);
      int last;
      int i;
      int c;
      last = do_w ? 33 : 0;
      if (do_c && (cd + 34 + hold) > last) last = cd + 34 + hold;
      for (int t = 0; t <= last; t++) begin
         c = t - cd;
         if (do_w) begin
            if (t == 0) chk("w_ready_before", load_ready, 1);
            else if (t <= 32) begin
               i = t - 1;
               chk("wr_en", wr_en, 1);
               chk("load_ready_busy", load_ready, 0);
               chk("rd", rd, wr);
               chk("data_rd", data_rd, bit_of(ww, i));
               chk("wr_next_en", wr_next_en, (i < 31) ? 1 : 0);
               chk("data_rd_next", data_rd_next, bit_of(ww, i + 1));
            end else if (t == 33) begin
               chk("w_ready_after", load_ready, 1);
               chk("wr_en_after", wr_en, 0);
            end
         end else begin
            chk("wr_en_quiet", wr_en, 0);
         end
         if (do_c) begin
            if (c == 0) chk("cap_idle_before", cap_busy, 0);
            else if (c >= 1 && c <= 32) begin
               chk("cap_busy", cap_busy, 1);
               chk("cap_valid_early", cap_valid, 0);
               chk("rs", rs, cr);
            end else if (c >= 33 && c <= 33 + hold) begin
               chk("cap_valid", cap_valid, 1);
               chk("cap_data", cap_data, cw);
               chk("rs_hold", rs, cr);
            end else if (c == 34 + hold) begin
               chk("cap_valid_drop", cap_valid, 0);
               chk("cap_busy_drop", cap_busy, 0);
            end
         end else begin
            chk("cap_busy_quiet", cap_busy, 0);
         end
         // drive inputs for the next rising edge
         load_valid = 1'b0;
         load_data  = $urandom;
         load_rd    = 4'($urandom);
         cap_start  = 1'b0;
         cap_rs     = 4'($urandom);
         cap_ready  = 1'b0;
         data_rs    = 1'($urandom);
         if (do_w) begin
            if (t == 0) begin
               load_valid = 1'b1;
               load_data  = ww;
               load_rd    = wr;
            end else if (t <= 32) begin
               load_valid = 1'($urandom);
            end
         end
         if (do_c) begin
            if (c == 0) begin
               cap_start = 1'b1;
               cap_rs    = cr;
            end else if (c >= 1 && c <= 32) begin
               data_rs = bit_of(cw, c - 1);
               if (poke && c == 10) cap_start = 1'b1;
            end else if (c >= 33 && c < 33 + hold) begin
               cap_start = 1'($urandom);
            end else if (c == 33 + hold) begin
               cap_ready = 1'b1;
            end
         end
         step();
      end
      load_valid = 1'b0;
      cap_start  = 1'b0;
      cap_ready  = 1'b0;
   endtask

   // Second capture started in the same cycle the first result is taken.
   task automatic run_b2b(input logic [31:0] w1, input logic [3:0] r1,
                          input logic [31:0] w2, input logic [3:0] r2);
      cap_start = 1'b1;
      cap_rs    = r1;
      step();
      cap_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         chk("b2b_rs1", rs, r1);
         data_rs = bit_of(w1, i);
         step();
      end
      chk("b2b_valid1", cap_valid, 1);
      chk("b2b_data1", cap_data, w1);
      cap_ready = 1'b1;
      cap_start = 1'b1;
      cap_rs    = r2;
      data_rs   = 1'($urandom);
      step();
      cap_ready = 1'b0;
      cap_start = 1'b0;
      chk("b2b_valid_drop", cap_valid, 0);
      chk("b2b_no_bubble", cap_busy, 1);
      for (int i = 0; i < 32; i++) begin
         chk("b2b_rs2", rs, r2);
         data_rs = bit_of(w2, i);
         step();
      end
      chk("b2b_valid2", cap_valid, 1);
      chk("b2b_data2", cap_data, w2);
      cap_ready = 1'b1;
      step();
      cap_ready = 1'b0;
      chk("b2b_idle", cap_busy, 0);
   endtask

   initial begin
      logic [31:0] w;
      rstn       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_rd    = '0;
      cap_start  = 1'b0;
      cap_rs     = '0;
      data_rs    = 1'b0;
      cap_ready  = 1'b0;
      repeat (3) step();
      chk("rst_load_ready", load_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_next_en", wr_next_en, 0);
      chk("rst_data_rd", data_rd, 0);
      chk("rst_data_rd_next", data_rd_next, 0);
      chk("rst_rd", rd, 0);
      chk("rst_rs", rs, 0);
      chk("rst_cap_busy", cap_busy, 0);
      chk("rst_cap_valid", cap_valid, 0);
      chk("rst_cap_data", cap_data, 0);
      rstn = 1'b1;
      step();

      // plain write
      run_ops(1'b1, 32'hA5A5_0F0F, 4'd5, 1'b0, 32'h0, 4'd0, 0, 1'b0, 0);
      // capture held for 10 cycles
      run_ops(1'b0, 32'h0, 4'd0, 1'b1, 32'h8000_0001, 4'd3, 0, 1'b0, 10);
      // back-to-back capture
      run_b2b(32'h1357_9BDF, 4'd4, 32'hFFFF_FFFF, 4'd11);
      // concurrent write and capture
      run_ops(1'b1, 32'h1234_5678, 4'd7, 1'b1, 32'hDEAD_BEEF, 4'd9, 3, 1'b0, 2);
      // stray cap_start during capture
      run_ops(1'b0, 32'h0, 4'd0, 1'b1, 32'h0F1E_2D3C, 4'd2, 0, 1'b1, 1);

      // reset in the middle of a write and a capture
      w          = 32'hC3C3_5AA5;
      load_valid = 1'b1;
      load_data  = w;
      load_rd    = 4'd6;
      cap_start  = 1'b1;
      cap_rs     = 4'd8;
      step();
      load_valid = 1'b0;
      cap_start  = 1'b0;
      repeat (10) step();
      chk("mid_bit10", data_rd, bit_of(w, 10));
      rstn = 1'b0;
      step();
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_load_ready", load_ready, 1);
      chk("mid_rst_rd", rd, 0);
      chk("mid_rst_cap_busy", cap_busy, 0);
      rstn = 1'b1;
      step();
      run_ops(1'b1, 32'h6B6B_0123, 4'd12, 1'b0, 32'h0, 4'd0, 0, 1'b0, 0);

      // randomized concurrent traffic
      for (int k = 0; k < 6; k++) begin
         run_ops(1'b1, $urandom, 4'($urandom), 1'b1, $urandom, 4'($urandom),
                 int'($urandom_range(0, 20)), (k % 2) == 1, int'($urandom_range(0, 5)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
